// File: rtl/buffer_reader_pkg.sv
// buffer_reader_pkg
// Shared definitions for the FIFO-to-RS-232 packet path: reader state encoding,
// packet length, default sync byte and the packet assembly helper. Also imported
// by the command processor so both sides agree on the packet layout.
package buffer_reader_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRead    = 2'd1,
        StCapture = 2'd2,
        StSend    = 2'd3
    } reader_state_e;

    localparam int unsigned PACKET_BYTES      = 6;
    localparam int unsigned PACKET_BITS       = PACKET_BYTES * 8;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    // Packet layout, first byte on the wire in the MSBs: sync, sequence, data[31:24]..data[7:0].
    function automatic logic [PACKET_BITS-1:0] build_packet(input logic [7:0]  sync_byte,
                                                            input logic [7:0]  seq,
                                                            input logic [31:0] data);
        return {sync_byte, seq, data};
    endfunction

endpackage

// File: rtl/buffer_reader.sv
// buffer_reader
// Drains 32-bit words from a FIFO in bursts and offers each word to the RS-232
// encoder as a 6-byte packet {SYNC_BYTE, seq, data}.
//
// Ports
//   clock               system clock (FIFO read port and command processor domain)
//   reset               synchronous, active-high reset
//   enable              streaming enable from the command processor
//   flush               level; drain the FIFO regardless of fill level
//   buffer_half_filled  FIFO AlmostFull flag
//   buffer_empty        FIFO Empty flag
//   buffer_data         FIFO Q, valid the cycle after buffer_read_enable
//   buffer_read_enable  FIFO RdEn, one-cycle pulse per word
//   tx_bytes            packet bytes, first byte in the MSBs
//   tx_num_bytes        number of valid bytes in tx_bytes
//   tx_valid            packet offered to the encoder
//   tx_ready            encoder can accept; transfer when tx_valid && tx_ready
//   words_sent          words transferred, wraps at 16'hFFFF
module buffer_reader
    import buffer_reader_pkg::*;
#(
    parameter int unsigned MAX_BYTES   = PACKET_BYTES,
    parameter int unsigned BURST_WORDS = 8,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   buffer_half_filled,
    input  logic                   buffer_empty,
    input  logic [31:0]            buffer_data,
    output logic                   buffer_read_enable,
    output logic [MAX_BYTES*8-1:0] tx_bytes,
    output logic [3:0]             tx_num_bytes,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [15:0]            words_sent
);

    localparam int unsigned TX_BITS  = MAX_BYTES * 8;
    // Packet is left-justified so the sync byte always sits in the MSBs.
    localparam int unsigned PAD_BITS = TX_BITS - PACKET_BITS;

    reader_state_e state;
    logic [7:0]    seq;
    logic [7:0]    burst_count;
    logic          start_burst;
    logic          burst_done;

    assign start_burst = enable && !buffer_empty && (buffer_half_filled || flush);
    assign burst_done  = (burst_count + 8'd1) == 8'(BURST_WORDS);

    // Decoded straight from the state and the live Empty flag so a read can
    // never be issued against an empty FIFO, even if Empty rises the same cycle.
    assign buffer_read_enable = (state == StRead) && !buffer_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            tx_valid     <= 1'b0;
            tx_bytes     <= '0;
            tx_num_bytes <= '0;
            seq          <= '0;
            words_sent   <= '0;
            burst_count  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_burst) begin
                        burst_count <= '0;
                        state       <= StRead;
                    end
                end
                StRead: begin
                    state <= buffer_empty ? StIdle : StCapture;
                end
                StCapture: begin
                    tx_bytes     <= TX_BITS'(build_packet(SYNC_BYTE, seq, buffer_data)) << PAD_BITS;
                    tx_num_bytes <= 4'(PACKET_BYTES);
                    tx_valid     <= 1'b1;
                    state        <= StSend;
                end
                StSend: begin
                    // tx_valid is high throughout StSend, so tx_ready alone marks the transfer.
                    if (tx_ready) begin
                        tx_valid    <= 1'b0;
                        seq         <= seq + 8'd1;
                        words_sent  <= words_sent + 16'd1;
                        burst_count <= burst_count + 8'd1;
                        if (burst_done || !enable || buffer_empty) begin
                            state <= StIdle;
                        end else begin
                            state <= StRead;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
module tb_buffer_reader;
    import buffer_reader_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        buffer_half_filled = 1'b0;
    logic        buffer_empty = 1'b1;
    logic [31:0] buffer_data = '0;
    logic        tx_ready = 1'b0;
    logic        buffer_read_enable;
    logic [47:0] tx_bytes;
    logic [3:0]  tx_num_bytes;
    logic        tx_valid;
    logic [15:0] words_sent;

    int checks = 0;
    int failures = 0;

    logic [31:0] fifo[$];
    logic [51:0] exp_q[$];
    logic [51:0] obs_q[$];
    logic [7:0]  exp_seq = 8'd0;
    int          rd_count = 0;
    int          rd_empty_count = 0;

    buffer_reader dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .flush              (flush),
        .buffer_half_filled (buffer_half_filled),
        .buffer_empty       (buffer_empty),
        .buffer_data        (buffer_data),
        .buffer_read_enable (buffer_read_enable),
        .tx_bytes           (tx_bytes),
        .tx_num_bytes       (tx_num_bytes),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .words_sent         (words_sent)
    );

    always #5 clock = ~clock;

    // FIFO model: Q updates on the edge that samples RdEn.
    always @(posedge clock) begin
        if (buffer_read_enable) begin
            rd_count++;
            if (buffer_empty || fifo.size() == 0) rd_empty_count++;
            else buffer_data <= fifo.pop_front();
        end
    end

    always @(negedge clock) buffer_empty = (fifo.size() == 0);

    // Collect every transfer; tasks pop and compare against the scoreboard.
    always @(negedge clock) begin
        if (tx_valid && tx_ready) obs_q.push_back({tx_num_bytes, tx_bytes});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        fifo.push_back(d);
        exp_q.push_back({4'd6, DEFAULT_SYNC_BYTE, exp_seq, d});
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (obs_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid);
        end
        checks++;
        if (buffer_read_enable !== 1'b0) begin
            failures++; $display("FAIL reset_rden got=%b exp=0", buffer_read_enable);
        end
        checks++;
        if (tx_bytes !== 48'h0) begin
            failures++; $display("FAIL reset_tx_bytes got=%h exp=0", tx_bytes);
        end
        checks++;
        if (tx_num_bytes !== 4'd0) begin
            failures++; $display("FAIL reset_num_bytes got=%0d exp=0", tx_num_bytes);
        end
        checks++;
        if (words_sent !== 16'd0) begin
            failures++; $display("FAIL reset_words_sent got=%0d exp=0", words_sent);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        int base = rd_count;
        bit ok;
        logic [51:0] got, exp;
        buffer_half_filled = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        tick();
        enable = 1'b1;
        tx_ready = 1'b1;
        wait_obs(8, 200, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL burst_timeout got=%0d packets exp=8", obs_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL burst_pkt%0d got=%h exp=%h", i, got, exp);
            end
        end
        repeat (6) tick();
        @(negedge clock);
        checks++;
        if (words_sent !== 16'd8) begin
            failures++; $display("FAIL burst_words_sent got=%0d exp=8", words_sent);
        end
        checks++;
        if (rd_count - base != 8) begin
            failures++; $display("FAIL burst_rden_count got=%0d exp=8", rd_count - base);
        end
        checks++;
        if (tx_valid !== 1'b0 || buffer_read_enable !== 1'b0) begin
            failures++;
            $display("FAIL burst_idle got valid=%b rden=%b exp 0 0", tx_valid, buffer_read_enable);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        logic v1, v2;
        logic [47:0] held;
        int bad = 0;
        logic [51:0] got, exp;
        tx_ready = 1'b0;
        push_word(32'hDEADBEEF);
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clock);
            if (buffer_read_enable) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL bp_rden_timeout got=0 exp=1");
        end
        @(negedge clock); v1 = tx_valid;
        @(negedge clock); v2 = tx_valid;
        checks++;
        if ({v1, v2} !== 2'b01) begin
            failures++; $display("FAIL bp_latency got=%b%b exp=01", v1, v2);
        end
        held = tx_bytes;
        repeat (20) begin
            @(negedge clock);
            if (tx_valid !== 1'b1 || tx_bytes !== held) bad++;
        end
        checks++;
        if (bad != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL bp_hold got=%0d unstable cycles, %0d transfers exp=0 0", bad, obs_q.size());
        end
        tick();
        tx_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (obs_q.size() != 1) begin
            failures++; $display("FAIL bp_transfer_count got=%0d exp=1", obs_q.size());
        end
        got = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL bp_pkt got=%h exp=%h", got, exp);
        end
        obs_q.delete();
        @(negedge clock);
        checks++;
        if (words_sent !== 16'd9 || tx_valid !== 1'b0) begin
            failures++; $display("FAIL bp_after got=%0d/%b exp=9/0", words_sent, tx_valid);
        end
        tick();
    endtask

    task automatic test_flush();
        int base = rd_count;
        int base_e = rd_empty_count;
        bit ok;
        logic [51:0] got, exp;
        buffer_half_filled = 1'b0;
        flush = 1'b1;
        tx_ready = 1'b1;
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        wait_obs(3, 100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL flush_timeout got=%0d exp=3", obs_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL flush_pkt%0d got=%h exp=%h", i, got, exp);
            end
        end
        repeat (10) tick();
        checks++;
        if (rd_count - base != 3) begin
            failures++; $display("FAIL flush_rden_count got=%0d exp=3", rd_count - base);
        end
        checks++;
        if (rd_empty_count != base_e) begin
            failures++; $display("FAIL flush_rden_empty got=%0d exp=%0d", rd_empty_count, base_e);
        end
        flush = 1'b0;
    endtask

    task automatic test_enable();
        int base = rd_count;
        int bad = 0;
        bit found;
        bit ok;
        logic [51:0] got, exp;
        enable = 1'b0;
        buffer_half_filled = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(32'hE0000000 + 32'(i));
        repeat (100) begin
            @(negedge clock);
            if (buffer_read_enable || tx_valid) bad++;
        end
        checks++;
        if (bad != 0 || rd_count != base) begin
            failures++; $display("FAIL en_off_activity got=%0d cycles exp=0", bad);
        end
        tick();
        tx_ready = 1'b0;
        enable = 1'b1;
        for (int p = 0; p < 2; p++) begin
            found = 1'b0;
            for (int c = 0; c < 50 && !found; c++) begin
                @(negedge clock);
                if (tx_valid) found = 1'b1;
            end
            checks++;
            if (!found) begin
                failures++; $display("FAIL en_valid_timeout_p%0d got=0 exp=1", p);
            end
            tick();
            if (p == 1) enable = 1'b0;
            tx_ready = 1'b1;
            tick();
            if (p == 0) tx_ready = 1'b0;
        end
        repeat (30) tick();
        checks++;
        if (obs_q.size() != 2 || rd_count - base != 2) begin
            failures++;
            $display("FAIL en_drop got=%0d pkts %0d reads exp=2 2", obs_q.size(), rd_count - base);
        end
        for (int i = 0; i < 2; i++) begin
            got = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL en_pkt%0d got=%h exp=%h", i, got, exp);
            end
        end
        obs_q.delete();
        enable = 1'b1;
        wait_obs(6, 200, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL en_resume_timeout got=%0d exp=6", obs_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            got = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL en_resume_pkt%0d got=%h exp=%h", i, got, exp);
            end
        end
        repeat (5) tick();
    endtask

    task automatic test_wrap();
        bit ok;
        int bad = 0;
        logic [51:0] got, exp;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
        exp_seq = 8'd0;
        enable = 1'b1;
        buffer_half_filled = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 300; i++) push_word(32'h10000000 + 32'(i));
        wait_obs(300, 3000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wrap_timeout got=%0d exp=300", obs_q.size());
        end
        for (int i = 0; i < 300; i++) begin
            got = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                if (bad < 10) $display("FAIL wrap_pkt%0d got=%h exp=%h", i, got, exp);
                bad++;
            end
        end
        repeat (5) tick();
        @(negedge clock);
        checks++;
        if (words_sent !== 16'd300) begin
            failures++; $display("FAIL wrap_words_sent got=%0d exp=300", words_sent);
        end
        tick();
    endtask

    task automatic test_reset_in_send();
        bit found = 1'b0;
        bit ok;
        logic [51:0] got, exp;
        tx_ready = 1'b0;
        push_word(32'hCAFE0001);
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clock);
            if (tx_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL rst_send_valid_timeout got=0 exp=1");
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (tx_valid !== 1'b0 || words_sent !== 16'd0 || tx_bytes !== 48'h0) begin
            failures++;
            $display("FAIL rst_send_clear got=%b/%0d/%h exp=0/0/0", tx_valid, words_sent, tx_bytes);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++; $display("FAIL rst_send_no_transfer got=%0d exp=0", obs_q.size());
        end
        exp_q.delete();
        obs_q.delete();
        exp_seq = 8'd0;
        tick();
        push_word(32'hCAFE0002);
        tx_ready = 1'b1;
        wait_obs(1, 50, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL rst_next_timeout got=0 exp=1");
        end
        got = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL rst_next_pkt got=%h exp=%h", got, exp);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_flush();
        test_enable();
        test_wrap();
        test_reset_in_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 Parameter MAX_BYTES, default 6: width of tx_bytes in bytes (tx_bytes is MAX_BYTES*8 bits).
REQ-002 Parameter BURST_WORDS, default 8: maximum number of FIFO words drained per burst (range 1..255).
REQ-003 Parameter SYNC_BYTE, default 8'hA5: first byte of every packet.
REQ-004 clock  in  1  system clock, the same domain as the FIFO read port and the command processor.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  streaming enable from the command processor.
REQ-007 flush  in  1  level; when high, drain the FIFO regardless of fill level.
REQ-008 buffer_half_filled  in  1  FIFO AlmostFull flag.
REQ-009 buffer_empty  in  1  FIFO Empty flag.
REQ-010 buffer_data  in  32  FIFO Q output, valid one cycle after buffer_read_enable.
REQ-011 buffer_read_enable  out  1  FIFO RdEn, one-cycle pulse per word.
REQ-012 tx_bytes  out  MAX_BYTES*8  packet bytes, first byte in the MSBs.
REQ-013 tx_num_bytes  out  4  number of valid bytes in tx_bytes.
REQ-014 tx_valid  out  1  packet offered to the RS-232 encoder.
REQ-015 tx_ready  in  1  encoder can accept; a transfer occurs on a cycle with tx_valid and tx_ready both high.
REQ-016 words_sent  out  16  count of words transferred, wraps at 16'hFFFF to 0.

Function
REQ-017 States: IDLE, READ, CAPTURE, SEND.
REQ-018 IDLE -> READ when enable=1, buffer_empty=0, and (buffer_half_filled=1 or flush=1); the burst word count clears to 0 on this transition.
REQ-019 READ: buffer_read_enable=1 for exactly one cycle if buffer_empty=0, then -> CAPTURE; if buffer_empty=1, no read is issued and the state goes to IDLE.
REQ-020 CAPTURE: latch buffer_data into the packet register, then -> SEND; from RdEn to tx_valid high is 2 cycles.
REQ-021 Packet: tx_bytes[47:40]=SYNC_BYTE, [39:32]=seq, [31:0]=data (data[31:24] sent first); tx_num_bytes=6.
REQ-022 SEND: tx_valid stays high and tx_bytes/tx_num_bytes are held stable until tx_ready=1.
REQ-023 On the SEND transfer cycle: tx_valid drops the next cycle, seq increments, words_sent increments, and the burst count increments.
REQ-024 After a SEND transfer, go to IDLE if burst count = BURST_WORDS, enable=0, or buffer_empty=1; otherwise go to READ.
REQ-025 seq is 8 bits and wraps from 255 to 0 with no gap.
REQ-026 buffer_read_enable is never asserted while buffer_empty=1, and never asserted in any state other than READ.
REQ-027 enable deasserted mid-burst: the word already read completes SEND, and no further read is issued.
REQ-028 tx_ready already high on entry to SEND: the transfer completes in that first SEND cycle.
REQ-029 When flush=1 and buffer_half_filled=0, bursts repeat until buffer_empty=1.

Reset
REQ-030 When reset is sampled high, the next state is IDLE, and buffer_read_enable=0, tx_valid=0, tx_bytes=0, tx_num_bytes=0, seq=0, words_sent=0, burst count=0.
REQ-031 Reset during SEND drops tx_valid at the next edge and discards the held word without incrementing any counter.

Structure
REQ-032 The state encoding, packet length (6), and SYNC_BYTE default live in the shared package used by the command processor.
REQ-033 Single module with no sub-modules; the packet register and counters are inline.

Verification
REQ-034 FIFO preloaded with 8 words 0x00000001..0x00000008, half_filled=1, enable=1, tx_ready=1 -> 8 packets A5,00..07 carrying the data in order; words_sent=8; then IDLE.
REQ-035 tx_ready held low for 20 cycles during SEND -> tx_valid stays high and tx_bytes stays constant; exactly one transfer occurs after tx_ready rises.
REQ-036 3 words preloaded, half_filled=0, flush=1 -> 3 packets sent; buffer_read_enable pulses exactly 3 times and never while empty.
REQ-037 enable=0 with half_filled=1 -> no RdEn and no tx_valid for 100 cycles; enable dropped after packet 2 of a burst -> exactly 2 packets sent.
REQ-038 300 words streamed -> seq sequence 0..255,0..43 with no gap; words_sent=300.
REQ-039 reset pulsed while tx_valid=1 -> tx_valid=0 next cycle, seq=0, words_sent=0; the next burst starts with seq 00.
